// File: rtl/grf_hazard_ctrl_pkg.sv
// Shared definitions for the GRF hazard/bypass controller: select encodings,
// the pipeline stage-entry record and a small tnew helper.
package grf_hazard_ctrl_pkg;

    localparam int GRF_ADDR_W = 5;
    localparam int GRF_T_W    = 2;

    // Tuse value meaning "this operand is not read at all"
    localparam logic [1:0] TUSE_UNUSED = 2'd3;

    // D-stage operand source
    localparam logic [1:0] FWD_GRF = 2'd0;
    localparam logic [1:0] FWD_E   = 2'd1;
    localparam logic [1:0] FWD_M   = 2'd2;
    localparam logic [1:0] FWD_W   = 2'd3;

    // E/M-stage operand source
    localparam logic [1:0] FWD_PIPE   = 2'd0;
    localparam logic [1:0] FWD_FROM_M = 2'd1;
    localparam logic [1:0] FWD_FROM_W = 2'd2;

    // One tracked instruction; dst == 0 means the instruction writes nothing
    typedef struct packed {
        logic [GRF_ADDR_W-1:0] dst;
        logic [GRF_T_W-1:0]    tnew;
        logic [GRF_ADDR_W-1:0] rs;
        logic [GRF_ADDR_W-1:0] rt;
    } stage_t;

    // Result countdown after one more stage, never going below zero
    function automatic logic [GRF_T_W-1:0] tnew_dec(input logic [GRF_T_W-1:0] t);
        return (t == '0) ? '0 : t - 1'b1;
    endfunction

endpackage

// File: rtl/grf_hazard_ctrl_fwd_match.sv
// Priority match of one source register against up to three producer slots,
// ordered youngest first. Reports which slot holds the nearest writer
// (1..3, 0 = none) and whether that writer's result is already available.
module grf_hazard_ctrl_fwd_match
    import grf_hazard_ctrl_pkg::*;
#(
    parameter int ADDR_W = GRF_ADDR_W,
    parameter int T_W    = GRF_T_W
) (
    input  logic [ADDR_W-1:0] src_i,
    input  logic [ADDR_W-1:0] dst0_i,
    input  logic [T_W-1:0]    tnew0_i,
    input  logic [ADDR_W-1:0] dst1_i,
    input  logic [T_W-1:0]    tnew1_i,
    input  logic [ADDR_W-1:0] dst2_i,
    input  logic [T_W-1:0]    tnew2_i,
    output logic [1:0]        sel_o,
    output logic              ready_o
);

    // Nearest writer wins; register 0 never matches anything
    always_comb begin
        sel_o   = 2'd0;
        ready_o = 1'b1;
        if (src_i != '0) begin
            if (dst0_i == src_i) begin
                sel_o   = 2'd1;
                ready_o = (tnew0_i == '0);
            end else if (dst1_i == src_i) begin
                sel_o   = 2'd2;
                ready_o = (tnew1_i == '0);
            end else if (dst2_i == src_i) begin
                sel_o   = 2'd3;
                ready_o = (tnew2_i == '0);
            end
        end
    end

endmodule

// File: rtl/grf_hazard_ctrl.sv
// Hazard and bypass controller for the 5-stage CPU. Tracks the writers in
// E, M and W, stalls D when an operand cannot arrive in time, and steers the
// bypass muxes of the D, E and M operand reads.
module grf_hazard_ctrl
    import grf_hazard_ctrl_pkg::*;
#(
    parameter int ADDR_W = GRF_ADDR_W,
    parameter int T_W    = GRF_T_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] d_rs,
    input  logic [ADDR_W-1:0] d_rt,
    input  logic [T_W-1:0]    d_tuse_rs,
    input  logic [T_W-1:0]    d_tuse_rt,
    input  logic              d_wr_en,
    input  logic [ADDR_W-1:0] d_wr_addr,
    input  logic [T_W-1:0]    d_tnew,
    output logic              stall,
    output logic [1:0]        d_fwd_rs_sel,
    output logic [1:0]        d_fwd_rt_sel,
    output logic [1:0]        e_fwd_rs_sel,
    output logic [1:0]        e_fwd_rt_sel,
    output logic              m_fwd_rt_sel
);

    stage_t            e_q, e_d;
    logic [ADDR_W-1:0] m_dst_q, m_dst_d;
    logic [T_W-1:0]    m_tnew_q, m_tnew_d;
    logic [ADDR_W-1:0] m_rt_q, m_rt_d;
    logic [ADDR_W-1:0] w_dst_q, w_dst_d;

    logic [1:0] d_rs_hit, d_rt_hit, e_rs_hit, e_rt_hit, m_rt_hit;
    logic       d_rs_rdy, d_rt_rdy, e_rs_rdy, e_rt_rdy, m_rt_rdy;

    // A source stalls when a pending writer in E or M will not have its
    // result ready by the time the consumer needs it. W is always ready.
    function automatic logic src_stalls(
        input logic [ADDR_W-1:0] src,
        input logic [T_W-1:0]    tuse,
        input logic [ADDR_W-1:0] e_dst,
        input logic [T_W-1:0]    e_tnew,
        input logic [ADDR_W-1:0] m_dst,
        input logic [T_W-1:0]    m_tnew
    );
        logic late_e;
        logic late_m;
        late_e = (e_dst == src) && (tuse < e_tnew);
        late_m = (m_dst == src) && (tuse < m_tnew);
        if (tuse == TUSE_UNUSED || src == '0) begin
            return 1'b0;
        end
        return late_e || late_m;
    endfunction

    // D operand lookups: E, then M, then W
    grf_hazard_ctrl_fwd_match #(.ADDR_W(ADDR_W), .T_W(T_W)) u_d_rs (
        .src_i(d_rs), .dst0_i(e_q.dst), .tnew0_i(e_q.tnew),
        .dst1_i(m_dst_q), .tnew1_i(m_tnew_q), .dst2_i(w_dst_q), .tnew2_i('0),
        .sel_o(d_rs_hit), .ready_o(d_rs_rdy)
    );
    grf_hazard_ctrl_fwd_match #(.ADDR_W(ADDR_W), .T_W(T_W)) u_d_rt (
        .src_i(d_rt), .dst0_i(e_q.dst), .tnew0_i(e_q.tnew),
        .dst1_i(m_dst_q), .tnew1_i(m_tnew_q), .dst2_i(w_dst_q), .tnew2_i('0),
        .sel_o(d_rt_hit), .ready_o(d_rt_rdy)
    );

    // E operand lookups: M, then W
    grf_hazard_ctrl_fwd_match #(.ADDR_W(ADDR_W), .T_W(T_W)) u_e_rs (
        .src_i(e_q.rs), .dst0_i(m_dst_q), .tnew0_i(m_tnew_q),
        .dst1_i(w_dst_q), .tnew1_i('0), .dst2_i('0), .tnew2_i('0),
        .sel_o(e_rs_hit), .ready_o(e_rs_rdy)
    );
    grf_hazard_ctrl_fwd_match #(.ADDR_W(ADDR_W), .T_W(T_W)) u_e_rt (
        .src_i(e_q.rt), .dst0_i(m_dst_q), .tnew0_i(m_tnew_q),
        .dst1_i(w_dst_q), .tnew1_i('0), .dst2_i('0), .tnew2_i('0),
        .sel_o(e_rt_hit), .ready_o(e_rt_rdy)
    );

    // M store-data lookup: W only
    grf_hazard_ctrl_fwd_match #(.ADDR_W(ADDR_W), .T_W(T_W)) u_m_rt (
        .src_i(m_rt_q), .dst0_i(w_dst_q), .tnew0_i('0),
        .dst1_i('0), .tnew1_i('0), .dst2_i('0), .tnew2_i('0),
        .sel_o(m_rt_hit), .ready_o(m_rt_rdy)
    );

    // Stall and bypass selects; a nearest writer that is not ready yet
    // hides older writers and leaves the operand on its normal path
    always_comb begin
        stall = src_stalls(d_rs, d_tuse_rs, e_q.dst, e_q.tnew, m_dst_q, m_tnew_q)
             || src_stalls(d_rt, d_tuse_rt, e_q.dst, e_q.tnew, m_dst_q, m_tnew_q);
        d_fwd_rs_sel = d_rs_rdy ? d_rs_hit : FWD_GRF;
        d_fwd_rt_sel = d_rt_rdy ? d_rt_hit : FWD_GRF;
        e_fwd_rs_sel = e_rs_rdy ? e_rs_hit : FWD_PIPE;
        e_fwd_rt_sel = e_rt_rdy ? e_rt_hit : FWD_PIPE;
        m_fwd_rt_sel = m_rt_rdy && (m_rt_hit == 2'd1);
    end

    // Next tracking state: shift E->M->W, bubble into E while stalled
    always_comb begin
        e_d = '0;
        if (!stall) begin
            e_d.dst  = d_wr_en ? d_wr_addr : '0;
            e_d.tnew = d_tnew;
            e_d.rs   = d_rs;
            e_d.rt   = d_rt;
        end
        m_dst_d  = e_q.dst;
        m_tnew_d = tnew_dec(e_q.tnew);
        m_rt_d   = e_q.rt;
        w_dst_d  = m_dst_q;
    end

    // Tracking registers, cleared immediately by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_q      <= '0;
            m_dst_q  <= '0;
            m_tnew_q <= '0;
            m_rt_q   <= '0;
            w_dst_q  <= '0;
        end else begin
            e_q      <= e_d;
            m_dst_q  <= m_dst_d;
            m_tnew_q <= m_tnew_d;
            m_rt_q   <= m_rt_d;
            w_dst_q  <= w_dst_d;
        end
    end

endmodule

// File: tb/tb_grf_hazard_ctrl.sv
// Self-checking bench for grf_hazard_ctrl: directed scenarios followed by
// random instruction streams, compared against an instruction-history model.
module tb_grf_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [4:0] d_rs = '0, d_rt = '0, d_wr_addr = '0;
    logic [1:0] d_tuse_rs = 2'd3, d_tuse_rt = 2'd3, d_tnew = '0;
    logic       d_wr_en = 1'b0;
    logic       stall;
    logic [1:0] d_fwd_rs_sel, d_fwd_rt_sel, e_fwd_rs_sel, e_fwd_rt_sel;
    logic       m_fwd_rt_sel;

    int checks = 0;
    int failures = 0;

    // Instruction history: entry k is the instruction that sat in E during
    // cycle k. At cycle t, age 0 = E, age 1 = M, age 2 = W.
    int t = 4;
    int hd[4096];
    int htn[4096];
    int hrs[4096];
    int hrt[4096];
    int htrs[4096];
    int htrt[4096];

    grf_hazard_ctrl dut (
        .clk(clk), .reset(reset),
        .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
        .d_wr_en(d_wr_en), .d_wr_addr(d_wr_addr), .d_tnew(d_tnew),
        .stall(stall), .d_fwd_rs_sel(d_fwd_rs_sel), .d_fwd_rt_sel(d_fwd_rt_sel),
        .e_fwd_rs_sel(e_fwd_rs_sel), .e_fwd_rt_sel(e_fwd_rt_sel),
        .m_fwd_rt_sel(m_fwd_rt_sel)
    );

    always #5 clk = ~clk;

    // Cycles left until the instruction of a given age has its result
    function automatic int remaining(int age);
        int r;
        if (age >= 2) return 0;
        r = htn[t - age] - age;
        return (r < 0) ? 0 : r;
    endfunction

    function automatic int m_stall_src(int src, int tuse);
        if (tuse == 3 || src == 0) return 0;
        for (int a = 0; a < 2; a++)
            if (hd[t - a] == src && tuse < remaining(a)) return 1;
        return 0;
    endfunction

    function automatic int m_stall();
        return (m_stall_src(d_rs, d_tuse_rs) != 0 || m_stall_src(d_rt, d_tuse_rt) != 0) ? 1 : 0;
    endfunction

    // Nearest producer of src among ages lo..2, coded relative to lo
    function automatic int m_sel(int src, int lo);
        if (src == 0) return 0;
        for (int a = lo; a <= 2; a++)
            if (hd[t - a] == src) return (remaining(a) == 0) ? (a - lo + 1) : 0;
        return 0;
    endfunction

    // E consumer needing its operand in E while the M producer is not ready
    function automatic int m_e_late(int src, int tuse);
        return (src != 0 && tuse <= 1 && hd[t - 1] == src && remaining(1) != 0) ? 1 : 0;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".stall"}, {7'd0, stall}, 8'(m_stall()));
        chk({tag, ".d_rs"}, {6'd0, d_fwd_rs_sel}, 8'(m_sel(d_rs, 0)));
        chk({tag, ".d_rt"}, {6'd0, d_fwd_rt_sel}, 8'(m_sel(d_rt, 0)));
        chk({tag, ".e_rs"}, {6'd0, e_fwd_rs_sel}, 8'(m_sel(hrs[t], 1)));
        chk({tag, ".e_rt"}, {6'd0, e_fwd_rt_sel}, 8'(m_sel(hrt[t], 1)));
        chk({tag, ".m_rt"}, {7'd0, m_fwd_rt_sel},
            8'((hrt[t - 1] != 0 && hrt[t - 1] == hd[t - 2]) ? 1 : 0));
        chk({tag, ".e_late_rs"}, 8'(m_e_late(hrs[t], htrs[t])), 8'd0);
        chk({tag, ".e_late_rt"}, 8'(m_e_late(hrt[t], htrt[t])), 8'd0);
    endtask

    task automatic set_entry(int k, int dst, int tn, int rs, int rt, int trs, int trt);
        hd[k] = dst; htn[k] = tn; hrs[k] = rs; hrt[k] = rt; htrs[k] = trs; htrt[k] = trt;
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset || m_stall() != 0)
            set_entry(t + 1, 0, 0, 0, 0, 3, 3);
        else
            set_entry(t + 1, d_wr_en ? int'(d_wr_addr) : 0, d_tnew, d_rs, d_rt,
                      d_tuse_rs, d_tuse_rt);
        t++;
        #1;
    endtask

    task automatic drive(int rs, int rt, int trs, int trt, int we, int wa, int tn);
        d_rs = 5'(rs); d_rt = 5'(rt); d_tuse_rs = 2'(trs); d_tuse_rt = 2'(trt);
        d_wr_en = 1'(we); d_wr_addr = 5'(wa); d_tnew = 2'(tn);
        #2;
    endtask

    task automatic apply_reset(input string tag);
        reset = 1'b1;
        for (int k = t - 2; k <= t; k++) set_entry(k, 0, 0, 0, 0, 3, 3);
        #1;
        check_all(tag);
        chk({tag, ".stall0"}, {7'd0, stall}, 8'd0);
        chk({tag, ".dsel0"}, {4'd0, d_fwd_rs_sel, d_fwd_rt_sel}, 8'd0);
        tick();
        reset = 1'b0;
    endtask

    initial begin
        apply_reset("init");

        // Reset while a load-use stall is pending
        drive(0, 0, 3, 3, 1, 8, 2); check_all("t1.lw"); tick();
        drive(8, 0, 0, 3, 0, 0, 0); check_all("t1.use");
        chk("t1.pre_stall", {7'd0, stall}, 8'd1);
        apply_reset("t1.rst");

        // Load-use: one bubble, then W bypass into E
        drive(0, 0, 3, 3, 1, 8, 2); check_all("t2.lw"); tick();
        drive(8, 0, 1, 3, 1, 12, 1); check_all("t2.add");
        chk("t2.stall", {7'd0, stall}, 8'd1); tick();
        check_all("t2.add2"); chk("t2.nostall", {7'd0, stall}, 8'd0); tick();
        drive(0, 0, 3, 3, 0, 0, 0); check_all("t2.e");
        chk("t2.e_rs_w", {6'd0, e_fwd_rs_sel}, 8'd2); tick();

        // ALU result consumed by a branch in D
        drive(0, 0, 3, 3, 1, 9, 1); check_all("t3.add"); tick();
        drive(9, 0, 0, 3, 0, 0, 0); check_all("t3.beq");
        chk("t3.stall", {7'd0, stall}, 8'd1); tick();
        check_all("t3.beq2"); chk("t3.nostall", {7'd0, stall}, 8'd0);
        chk("t3.d_rs_m", {6'd0, d_fwd_rs_sel}, 8'd2); tick();

        // Two writers of $10: nearest wins, unready nearest blocks fallback
        drive(0, 0, 3, 3, 1, 10, 1); check_all("t4.w1"); tick();
        drive(0, 0, 3, 3, 1, 10, 0); check_all("t4.w2"); tick();
        drive(0, 10, 3, 3, 0, 0, 0); check_all("t4.rd");
        chk("t4.d_rt_e", {6'd0, d_fwd_rt_sel}, 8'd1); tick();
        drive(0, 0, 3, 3, 1, 10, 0); check_all("t4.w3"); tick();
        drive(0, 0, 3, 3, 1, 10, 1); check_all("t4.w4"); tick();
        drive(0, 10, 3, 3, 0, 0, 0); check_all("t4.rd2");
        chk("t4.d_rt_0", {6'd0, d_fwd_rt_sel}, 8'd0); tick();

        // Register 0 and disabled writes never create hazards
        drive(0, 0, 3, 3, 1, 0, 2); check_all("t5.w0"); tick();
        drive(0, 0, 0, 0, 0, 5, 2); check_all("t5.r0");
        chk("t5.stall", {7'd0, stall}, 8'd0);
        chk("t5.sels", {2'd0, d_fwd_rs_sel, d_fwd_rt_sel, e_fwd_rs_sel}, 8'd0); tick();
        drive(5, 5, 0, 0, 0, 0, 0); check_all("t5.we0");
        chk("t5.stall2", {7'd0, stall}, 8'd0); tick();

        // Load then store of the loaded value: store data bypassed from W
        drive(0, 0, 3, 3, 1, 11, 2); check_all("t6.lw"); tick();
        drive(1, 11, 1, 2, 0, 0, 0); check_all("t6.sw");
        chk("t6.stall", {7'd0, stall}, 8'd0); tick();
        drive(0, 0, 3, 3, 0, 0, 0); check_all("t6.swE"); tick();
        check_all("t6.swM"); chk("t6.m_rt_w", {7'd0, m_fwd_rt_sel}, 8'd1); tick();

        // Random instruction streams over a small register set
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                apply_reset("rnd.rst");
            end else begin
                drive($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 7),
                      $urandom_range(0, 2));
                check_all("rnd");
                tick();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
